// File: rtl/twiddle_combine_pipe_if.sv
// Bundle of the twiddle_combine_pipe input/output handshakes and status.
// slave is the pipeline's view; master is the producer/consumer view.
interface twiddle_combine_pipe_if #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned IDX_WIDTH  = 6
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_rere;
  logic signed [DATA_WIDTH-1:0] in_imim;
  logic signed [DATA_WIDTH-1:0] in_reim;
  logic signed [DATA_WIDTH-1:0] in_imre;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_real;
  logic signed [DATA_WIDTH-1:0] out_imag;
  logic [IDX_WIDTH-1:0]         out_index;
  logic                         out_last;
  logic                         sat_flag;
  logic                         clear_sat;

  modport master (
    output in_valid, in_rere, in_imim, in_reim, in_imre, out_ready, clear_sat,
    input  in_ready, out_valid, out_real, out_imag, out_index, out_last, sat_flag
  );

  modport slave (
    input  in_valid, in_rere, in_imim, in_reim, in_imre, out_ready, clear_sat,
    output in_ready, out_valid, out_real, out_imag, out_index, out_last, sat_flag
  );
endinterface

// File: rtl/twiddle_combine_pipe.sv
// Combines four twiddle partial products into real/imag through a 2-stage valid/ready pipe.
// Define TWIDDLE_COMBINE_SAT_EN for saturating results and a sticky sat_flag; default wraps.
module twiddle_combine_pipe #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned FFT_POINTS = 64,
  parameter int unsigned IDX_WIDTH  = 6
) (
  input logic                   clk,
  input logic                   rst_n,
  twiddle_combine_pipe_if.slave bus
);

  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(FFT_POINTS - 1);

  logic                         s1_valid_q, s1_valid_d;
  logic signed [DATA_WIDTH-1:0] s1_rere_q, s1_rere_d;
  logic signed [DATA_WIDTH-1:0] s1_imim_q, s1_imim_d;
  logic signed [DATA_WIDTH-1:0] s1_reim_q, s1_reim_d;
  logic signed [DATA_WIDTH-1:0] s1_imre_q, s1_imre_d;
  logic                         s2_valid_q, s2_valid_d;
  logic signed [DATA_WIDTH-1:0] s2_real_q, s2_real_d;
  logic signed [DATA_WIDTH-1:0] s2_imag_q, s2_imag_d;
  logic [IDX_WIDTH-1:0]         idx_q, idx_d;
  logic                         sat_q, sat_d;

  logic                         s1_adv, s2_adv, s1_load, s2_load;
  logic signed [DATA_WIDTH:0]   sum_re, sum_im;
  logic signed [DATA_WIDTH-1:0] res_re, res_im;

  always_comb begin
    s2_adv  = !s2_valid_q || bus.out_ready;
    s1_adv  = !s1_valid_q || s2_adv;
    s1_load = bus.in_valid && s1_adv;
    s2_load = s1_valid_q && s2_adv;
  end

  // One guard bit so the add/sub itself can never overflow.
  always_comb begin
    sum_re = {s1_rere_q[DATA_WIDTH-1], s1_rere_q} - {s1_imim_q[DATA_WIDTH-1], s1_imim_q};
    sum_im = {s1_reim_q[DATA_WIDTH-1], s1_reim_q} + {s1_imre_q[DATA_WIDTH-1], s1_imre_q};
  end

`ifdef TWIDDLE_COMBINE_SAT_EN
  logic ovf_re, ovf_im;

  // Guard bit disagreeing with the result sign bit means out of range; clamp toward the guard sign.
  always_comb begin
    ovf_re = sum_re[DATA_WIDTH] ^ sum_re[DATA_WIDTH-1];
    ovf_im = sum_im[DATA_WIDTH] ^ sum_im[DATA_WIDTH-1];
    res_re = ovf_re ? {sum_re[DATA_WIDTH], {(DATA_WIDTH-1){~sum_re[DATA_WIDTH]}}}
                    : sum_re[DATA_WIDTH-1:0];
    res_im = ovf_im ? {sum_im[DATA_WIDTH], {(DATA_WIDTH-1){~sum_im[DATA_WIDTH]}}}
                    : sum_im[DATA_WIDTH-1:0];
  end

  always_comb begin
    sat_d = sat_q;
    if (s2_load && (ovf_re || ovf_im)) begin
      sat_d = 1'b1;
    end else if (bus.clear_sat) begin
      sat_d = 1'b0;
    end
  end
`else
  logic unused_sat;

  always_comb begin
    res_re = sum_re[DATA_WIDTH-1:0];
    res_im = sum_im[DATA_WIDTH-1:0];
    sat_d  = 1'b0;
  end

  assign unused_sat = ^{sum_re[DATA_WIDTH], sum_im[DATA_WIDTH], bus.clear_sat};
`endif

  always_comb begin
    s1_valid_d = s1_adv ? bus.in_valid : s1_valid_q;
    s1_rere_d  = s1_rere_q;
    s1_imim_d  = s1_imim_q;
    s1_reim_d  = s1_reim_q;
    s1_imre_d  = s1_imre_q;
    if (s1_load) begin
      s1_rere_d = bus.in_rere;
      s1_imim_d = bus.in_imim;
      s1_reim_d = bus.in_reim;
      s1_imre_d = bus.in_imre;
    end

    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_real_d  = s2_real_q;
    s2_imag_d  = s2_imag_q;
    if (s2_load) begin
      s2_real_d = res_re;
      s2_imag_d = res_im;
    end

    // Index tracks the entry on the outputs, so it moves only on an output transfer.
    idx_d = idx_q;
    if (s2_valid_q && bus.out_ready) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_rere_q  <= '0;
      s1_imim_q  <= '0;
      s1_reim_q  <= '0;
      s1_imre_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_real_q  <= '0;
      s2_imag_q  <= '0;
      idx_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_rere_q  <= s1_rere_d;
      s1_imim_q  <= s1_imim_d;
      s1_reim_q  <= s1_reim_d;
      s1_imre_q  <= s1_imre_d;
      s2_valid_q <= s2_valid_d;
      s2_real_q  <= s2_real_d;
      s2_imag_q  <= s2_imag_d;
      idx_q      <= idx_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_real  = s2_real_q;
  assign bus.out_imag  = s2_imag_q;
  assign bus.out_index = idx_q;
  assign bus.out_last  = (idx_q == LastIdx);
  assign bus.sat_flag  = sat_q;

endmodule
